// File: rtl/hiscore_ram_arbiter_if.sv
// rtl/hiscore_ram_arbiter_if.sv - CPU, hiscore and work-RAM signal bundle for the arbiter
interface hiscore_ram_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  logic          cpu_wr;
  logic [DW-1:0] cpu_dout;
  logic          cpu_hold;

  logic [AW-1:0] hs_address;
  logic [DW-1:0] hs_data_in;
  logic          hs_write;
  logic          hs_access_read;
  logic          hs_access_write;
  logic [DW-1:0] hs_data_out;
  logic          hs_grant;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  logic          hs_viol;

  // Arbiter side
  modport slave (
    input  cpu_addr, cpu_din, cpu_wr,
    input  hs_address, hs_data_in, hs_write, hs_access_read, hs_access_write,
    input  ram_dout,
    output cpu_dout, cpu_hold,
    output hs_data_out, hs_grant,
    output ram_addr, ram_din, ram_we,
    output hs_viol
  );

  // Environment side: CPU decode, hiscore engine and work RAM
  modport master (
    output cpu_addr, cpu_din, cpu_wr,
    output hs_address, hs_data_in, hs_write, hs_access_read, hs_access_write,
    output ram_dout,
    input  cpu_dout, cpu_hold,
    input  hs_data_out, hs_grant,
    input  ram_addr, ram_din, ram_we,
    input  hs_viol
  );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// rtl/hiscore_ram_arbiter.sv - work-RAM port arbiter between main CPU and hiscore engine
module hiscore_ram_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int SETTLE   = 4,
  parameter int MAX_HOLD = 4096
) (
  input  logic                 clkm_master,
  input  logic                 RESET_n,
  hiscore_ram_arbiter_if.slave bus
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam int WW = $clog2(MAX_HOLD) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [WW-1:0] WD_LAST  = WW'(MAX_HOLD - 1);
  localparam logic [WW-1:0] WD_MAX   = '1;

  typedef enum logic [1:0] {
    ST_CPU   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GRANT = 2'd2,
    ST_REL   = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          wd_fire;

  logic          req;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] din_mux;
  logic          we_mux;
  logic          hold_q;
  logic          grant_q;

  logic          viol;
  logic          prev_grant;
  logic          prev_cpu_side;
  logic [DW-1:0] cpu_dout_r;
  logic [DW-1:0] hs_dout_r;

  assign req = bus.hs_access_read | bus.hs_access_write;

  // State register plus the settle and watchdog counters
  always_ff @(posedge clkm_master or negedge RESET_n) begin
    if (!RESET_n) begin
      state <= ST_CPU;
      cnt   <= '0;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      wd    <= wd_nxt;
    end
  end

  // Next state, counter updates and RAM port mux
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    wd_nxt    = wd;
    wd_fire   = 1'b0;
    addr_mux  = bus.cpu_addr;
    din_mux   = bus.cpu_din;
    we_mux    = bus.cpu_wr;
    hold_q    = 1'b0;
    grant_q   = 1'b0;
    case (state)
      ST_CPU: begin
        // A CPU write coinciding with the request still goes through
        if (req) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        // CPU keeps the port so a write already on the bus can finish
        hold_q = 1'b1;
        if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
        if (!req) begin
          state_nxt = ST_REL;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_GRANT;
          wd_nxt    = '0;
        end
      end
      ST_GRANT: begin
        hold_q   = 1'b1;
        grant_q  = 1'b1;
        addr_mux = bus.hs_address;
        din_mux  = bus.hs_data_in;
        we_mux   = bus.hs_write;
        if (wd != WD_MAX) wd_nxt = wd + 1'b1;
        if (!req) begin
          state_nxt = ST_REL;
        end else if (wd == WD_LAST) begin
          state_nxt = ST_REL;
          wd_fire   = 1'b1;
        end
      end
      ST_REL: begin
        // One quiet cycle before the CPU gets the port back
        hold_q    = 1'b1;
        we_mux    = 1'b0;
        state_nxt = ST_CPU;
      end
      default: begin
        state_nxt = ST_CPU;
      end
    endcase
  end

  // Sticky violation flag: stray hiscore write or watchdog expiry
  always_ff @(posedge clkm_master or negedge RESET_n) begin
    if (!RESET_n) begin
      viol <= 1'b0;
    end else if ((bus.hs_write && state != ST_GRANT) || wd_fire) begin
      viol <= 1'b1;
    end
  end

  // Read-data capture, steered by who owned the port on the previous cycle
  always_ff @(posedge clkm_master or negedge RESET_n) begin
    if (!RESET_n) begin
      prev_grant    <= 1'b0;
      prev_cpu_side <= 1'b0;
      cpu_dout_r    <= '0;
      hs_dout_r     <= '0;
    end else begin
      prev_grant    <= (state == ST_GRANT);
      prev_cpu_side <= (state == ST_CPU) || (state == ST_HOLD);
      if (prev_grant)    hs_dout_r  <= bus.ram_dout;
      if (prev_cpu_side) cpu_dout_r <= bus.ram_dout;
    end
  end

  assign bus.ram_addr    = addr_mux;
  assign bus.ram_din     = din_mux;
  assign bus.ram_we      = we_mux & RESET_n;
  assign bus.cpu_hold    = hold_q;
  assign bus.hs_grant    = grant_q;
  assign bus.hs_viol     = viol;
  assign bus.cpu_dout    = cpu_dout_r;
  assign bus.hs_data_out = hs_dout_r;

endmodule
